// File: rtl/nn_fixed_pkg.sv
// rtl/nn_fixed_pkg.sv - shared fixed-point types, activation encodings and saturation helper
package nn_fixed_pkg;

    typedef enum logic [1:0] {
        ACT_NONE  = 2'd0,
        ACT_RELU  = 2'd1,
        ACT_LEAKY = 2'd2,
        ACT_HSIG  = 2'd3
    } act_sel_e;

    localparam int FRAC_BITS_DEF = 8;

    // Clamp a wide signed value into the signed range of a dw-bit word.
    function automatic logic signed [63:0] saturate(input logic signed [63:0] v, input int dw);
        logic signed [63:0] hi;
        logic signed [63:0] lo;
        hi = (64'sd1 <<< (dw - 1)) - 64'sd1;
        lo = -(64'sd1 <<< (dw - 1));
        if (v > hi) begin
            saturate = hi;
        end else if (v < lo) begin
            saturate = lo;
        end else begin
            saturate = v;
        end
    endfunction

endpackage

// File: rtl/bias_activation_stage_if.sv
// rtl/bias_activation_stage_if.sv - accumulator input, bias ROM and result output signals
interface bias_activation_stage_if #(
    parameter int ACC_WIDTH  = 32,
    parameter int DATA_WIDTH = 16,
    parameter int ADDR_WIDTH = 7
);
    logic                         in_valid;
    logic                         in_ready;
    logic signed [ACC_WIDTH-1:0]  in_data;

    logic                         bias_rd_en;
    logic [ADDR_WIDTH-1:0]        bias_addr;
    logic signed [DATA_WIDTH-1:0] bias_data;

    logic                         out_valid;
    logic                         out_ready;
    logic signed [DATA_WIDTH-1:0] out_data;
    logic                         out_sat;
    logic                         out_last;

    // Stage view: consumes accumulators and bias words, produces results.
    modport slave (
        input  in_valid, in_data, bias_data, out_ready,
        output in_ready, bias_rd_en, bias_addr, out_valid, out_data, out_sat, out_last
    );

    // Environment view: upstream producer, bias ROM and downstream consumer.
    modport master (
        output in_valid, in_data, bias_data, out_ready,
        input  in_ready, bias_rd_en, bias_addr, out_valid, out_data, out_sat, out_last
    );
endinterface

// File: rtl/activation_unit.sv
// rtl/activation_unit.sv - combinational activation selection followed by output saturation
module activation_unit
    import nn_fixed_pkg::*;
#(
    parameter int RW          = 34,
    parameter int DATA_WIDTH  = 16,
    parameter int FRAC_BITS   = FRAC_BITS_DEF,
    parameter int LEAKY_SHIFT = 3
) (
    input  logic signed [RW-1:0]         r,
    input  act_sel_e                     act,
    output logic signed [DATA_WIDTH-1:0] y,
    output logic                         sat
);

    localparam logic signed [RW-1:0] HALF = RW'(2 ** (FRAC_BITS - 1));
    localparam logic signed [RW-1:0] ONE  = RW'(2 ** FRAC_BITS);

    logic signed [RW-1:0] a;
    logic signed [RW-1:0] hs;
    logic signed [63:0]   wide;
    logic signed [63:0]   clip;

    // Apply the selected activation at full width, then clip to the output word.
    always_comb begin
        hs = (r >>> 2) + HALF;
        a  = r;
        case (act)
            ACT_RELU:  a = r[RW-1] ? '0 : r;
            ACT_LEAKY: a = r[RW-1] ? (r >>> LEAKY_SHIFT) : r;
            ACT_HSIG: begin
                if (hs < 0) begin
                    a = '0;
                end else if (hs > ONE) begin
                    a = ONE;
                end else begin
                    a = hs;
                end
            end
            default:   a = r;
        endcase
        wide = {{(64 - RW){a[RW-1]}}, a};
        clip = saturate(wide, DATA_WIDTH);
        y    = clip[DATA_WIDTH-1:0];
        sat  = (clip != wide);
    end

endmodule

// File: rtl/bias_activation_stage.sv
// rtl/bias_activation_stage.sv - bias add, round/requantise, activation and saturation stream stage
module bias_activation_stage
    import nn_fixed_pkg::*;
#(
    parameter int OUTPUT_WIDTH = 128,
    parameter int DATA_WIDTH   = 16,
    parameter int FRAC_BITS    = FRAC_BITS_DEF,
    parameter int ACC_WIDTH    = 32,
    parameter int LEAKY_SHIFT  = 3,
    parameter int ADDR_WIDTH   = (OUTPUT_WIDTH > 1) ? $clog2(OUTPUT_WIDTH) : 1
) (
    input  logic                    clk,
    input  logic                    rst,
    input  logic [1:0]              act_sel,
    bias_activation_stage_if.slave  bus,
    output logic                    done
);

    localparam int                    RW       = ACC_WIDTH + 2;
    localparam logic [ADDR_WIDTH-1:0] LAST_IDX = ADDR_WIDTH'(OUTPUT_WIDTH - 1);
    localparam logic signed [RW-1:0]  RND      = RW'(2 ** (FRAC_BITS - 1));

    logic en;
    logic accept;

    logic [ADDR_WIDTH-1:0]        idx_q, idx_d;
    act_sel_e                     act_q, act_d;
    logic                         s1_valid_q, s1_valid_d;
    logic signed [ACC_WIDTH-1:0]  s1_acc_q, s1_acc_d;
    logic                         s1_last_q, s1_last_d;
    logic                         bias_pend_q, bias_pend_d;
    logic signed [DATA_WIDTH-1:0] bias_hold_q, bias_hold_d;
    logic                         out_valid_q, out_valid_d;
    logic signed [DATA_WIDTH-1:0] out_data_q, out_data_d;
    logic                         out_sat_q, out_sat_d;
    logic                         out_last_q, out_last_d;

    logic signed [DATA_WIDTH-1:0] bias_eff;
    logic signed [RW-1:0]         acc_ext;
    logic signed [RW-1:0]         bias_ext;
    logic signed [RW-1:0]         sum;
    logic signed [RW-1:0]         r;
    logic signed [DATA_WIDTH-1:0] act_y;
    logic                         act_sat;

    // Whole pipeline advances together whenever the output slot is free or draining.
    always_comb begin
        en             = !out_valid_q || bus.out_ready;
        accept         = bus.in_valid && en;
        bus.in_ready   = en;
        bus.bias_rd_en = accept;
        bus.bias_addr  = idx_q;
        bus.out_valid  = out_valid_q;
        bus.out_data   = out_data_q;
        bus.out_sat    = out_sat_q;
        bus.out_last   = out_last_q;
        done           = out_valid_q && bus.out_ready && out_last_q;
    end

    // Neuron counter, frame-wide activation latch, stage-1 capture and bias hold.
    always_comb begin
        idx_d       = idx_q;
        act_d       = act_q;
        s1_valid_d  = s1_valid_q;
        s1_acc_d    = s1_acc_q;
        s1_last_d   = s1_last_q;
        bias_pend_d = accept;
        bias_hold_d = bias_pend_q ? bus.bias_data : bias_hold_q;
        if (accept) begin
            idx_d = (idx_q == LAST_IDX) ? '0 : idx_q + 1'b1;
            if (idx_q == '0) begin
                act_d = act_sel_e'(act_sel);
            end
        end
        if (en) begin
            s1_valid_d = accept;
            if (accept) begin
                s1_acc_d  = bus.in_data;
                s1_last_d = (idx_q == LAST_IDX);
            end
        end
    end

    // Bias arrives the cycle after the read; afterwards the hold register keeps it through stalls.
    always_comb begin
        bias_eff = bias_pend_q ? bus.bias_data : bias_hold_q;
        acc_ext  = {{2{s1_acc_q[ACC_WIDTH-1]}}, s1_acc_q};
        bias_ext = {{(RW - DATA_WIDTH){bias_eff[DATA_WIDTH-1]}}, bias_eff};
        sum      = acc_ext + (bias_ext <<< FRAC_BITS);
        r        = (sum + RND) >>> FRAC_BITS;
    end

    activation_unit #(
        .RW          (RW),
        .DATA_WIDTH  (DATA_WIDTH),
        .FRAC_BITS   (FRAC_BITS),
        .LEAKY_SHIFT (LEAKY_SHIFT)
    ) u_act (
        .r   (r),
        .act (act_q),
        .y   (act_y),
        .sat (act_sat)
    );

    // Output register: loads on advance, otherwise holds the presented result.
    always_comb begin
        out_valid_d = out_valid_q;
        out_data_d  = out_data_q;
        out_sat_d   = out_sat_q;
        out_last_d  = out_last_q;
        if (en) begin
            out_valid_d = s1_valid_q;
            if (s1_valid_q) begin
                out_data_d = act_y;
                out_sat_d  = act_sat;
                out_last_d = s1_last_q;
            end
        end
    end

    // State registers with synchronous reset that drops everything in flight.
    always_ff @(posedge clk) begin
        if (rst) begin
            idx_q       <= '0;
            act_q       <= ACT_NONE;
            s1_valid_q  <= 1'b0;
            s1_acc_q    <= '0;
            s1_last_q   <= 1'b0;
            bias_pend_q <= 1'b0;
            bias_hold_q <= '0;
            out_valid_q <= 1'b0;
            out_data_q  <= '0;
            out_sat_q   <= 1'b0;
            out_last_q  <= 1'b0;
        end else begin
            idx_q       <= idx_d;
            act_q       <= act_d;
            s1_valid_q  <= s1_valid_d;
            s1_acc_q    <= s1_acc_d;
            s1_last_q   <= s1_last_d;
            bias_pend_q <= bias_pend_d;
            bias_hold_q <= bias_hold_d;
            out_valid_q <= out_valid_d;
            out_data_q  <= out_data_d;
            out_sat_q   <= out_sat_d;
            out_last_q  <= out_last_d;
        end
    end

endmodule
